// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the IF/MEM unified-memory arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_priority.sv
// ============================================================================
// Module      : mem_arb_priority
// Description : Grant selection between data and instruction ports, with an
//               optional starvation counter (MEM_ARB_STARVE_GUARD_EN).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       pc_reset_n,
    input  logic       i_idle,
    input  logic       i_d_req,
    input  logic       i_if_req,
    output logic       o_grant,
    output arb_owner_t o_owner
);

    logic w_starved;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt == c_CNT_W'(STARVE_LIMIT));

    // Counts consecutive data grants that left a pending fetch waiting.
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            r_starve_cnt <= '0;
        end else if (i_idle) begin
            if (!i_if_req) begin
                r_starve_cnt <= '0;
            end else if (o_grant && (o_owner == INST)) begin
                r_starve_cnt <= '0;
            end else if (o_grant && (o_owner == DATA)) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end
    end
`else
    localparam int c_unused_limit = STARVE_LIMIT;

    logic w_unused_ok;

    assign w_starved   = 1'b0;
    assign w_unused_ok = &{1'b0, clk, pc_reset_n};
`endif

    assign o_grant = i_idle & (i_d_req | i_if_req);

    always_comb begin
        o_owner = DATA;
        if (i_if_req && (w_starved || !i_d_req)) begin
            o_owner = INST;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port unified memory arbiter for IF and MEM stages;
//               MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          pc_reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    arb_owner_t       r_owner;
    logic             r_is_write;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [DW-1:0]    r_if_rdata;
    logic [DW-1:0]    r_d_rdata;
    logic             r_mem_en;
    logic             r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;

    logic             w_grant;
    arb_owner_t       w_grant_owner;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clk        (clk),
        .pc_reset_n (pc_reset_n),
        .i_idle     (r_state == IDLE),
        .i_d_req    (d_req),
        .i_if_req   (if_req),
        .o_grant    (w_grant),
        .o_owner    (w_grant_owner)
    );

    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = ISSUE;
            ISSUE:   w_state_next = r_is_write ? DONE : WAIT;
            WAIT:    if (r_lat_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The mem_* registers double as the request latch: loaded once at the
    // grant, so requester inputs are ignored for the rest of the access.
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            r_owner     <= INST;
            r_is_write  <= 1'b0;
            r_lat_cnt   <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_grant_owner;
                        r_mem_en <= 1'b1;
                        if (w_grant_owner == DATA) begin
                            r_is_write  <= d_we;
                            r_mem_we    <= d_we;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                        end else begin
                            r_is_write  <= 1'b0;
                            r_mem_addr  <= if_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (!r_is_write) begin
                        r_lat_cnt <= LAT_W'(MEM_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == '0) begin
                        if (r_owner == DATA) begin
                            r_d_rdata <= mem_rdata;
                        end else begin
                            r_if_rdata <= mem_rdata;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_valid  = (r_state == DONE) && (r_owner == INST);
    assign d_valid   = (r_state == DONE) && (r_owner == DATA);
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire
